// File: rtl/dwt_envelope_pipe.sv
// Multi-level Daubechies DWT cascade with envelope extraction.
// Each level filters its input with the loaded low-pass h[k] and its QMF mirror
// g[k] = (-1)^k * h[N_TAPS-1-k], decimates by two, and passes the approximation
// on to the next level. The last level feeds a held output register with
// valid/ready flow control.

module dwt_level #(
   parameter int DATA_W    = 32,
   parameter int COEF_W    = 16,
   parameter int COEF_FRAC = 15,
   parameter int N_TAPS    = 20
) (
   input  logic                          CLK,
   input  logic                          RST,
   input  logic                          clr,
   input  logic                          take,
   input  logic [DATA_W-1:0]             x_in,
   input  logic [N_TAPS-1:0][COEF_W-1:0] h,
   input  logic                          sel_d,
   output logic                          emit,
   output logic [DATA_W-1:0]             y
);
   localparam int ACC_W = DATA_W + COEF_W + $clog2(N_TAPS);
   localparam int CNT_W = $clog2(N_TAPS + 1);
   localparam logic signed [ACC_W-1:0] HALF = ACC_W'(1) <<< (COEF_FRAC - 1);
   localparam logic signed [ACC_W-1:0] MAXV = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] MINV = ~MAXV;

   logic [N_TAPS-1:0][DATA_W-1:0] win;      // win[0] is the newest sample
   logic [N_TAPS-1:0][DATA_W-1:0] win_nxt;
   logic [CNT_W-1:0]              fill;
   logic [CNT_W-1:0]              fill_inc;
   logic                          phase;
   logic signed [ACC_W-1:0]       acc_a, acc_d, xe;

   // Round half up, then clamp to the signed output range.
   function automatic logic [DATA_W-1:0] rnd_sat(input logic signed [ACC_W-1:0] v);
      logic signed [ACC_W-1:0] r;
      r = (v + HALF) >>> COEF_FRAC;
      if (r > MAXV)      return MAXV[DATA_W-1:0];
      else if (r < MINV) return MINV[DATA_W-1:0];
      else               return r[DATA_W-1:0];
   endfunction

   // Window as it will be once the incoming sample is shifted in.
   always_comb begin
      win_nxt    = win;
      win_nxt[0] = x_in;
      for (int k = 1; k < N_TAPS; k++) win_nxt[k] = win[k-1];
   end

   // Full-precision MACs; the high-pass taps are mirrored and sign-alternated here.
   always_comb begin
      acc_a = '0;
      acc_d = '0;
      xe    = '0;
      for (int k = 0; k < N_TAPS; k++) begin
         xe    = ACC_W'($signed(win_nxt[k]));
         acc_a = acc_a + xe * ACC_W'($signed(h[k]));
         if (k % 2 == 0) acc_d = acc_d + xe * ACC_W'($signed(h[N_TAPS-1-k]));
         else            acc_d = acc_d - xe * ACC_W'($signed(h[N_TAPS-1-k]));
      end
   end

   assign fill_inc = (fill == CNT_W'(N_TAPS)) ? fill : fill + 1'b1;
   assign emit     = take & phase & (fill_inc == CNT_W'(N_TAPS));
   assign y        = sel_d ? rnd_sat(acc_d) : rnd_sat(acc_a);

   // Delay line, warm-up counter and decimation phase advance per consumed sample.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         win   <= '0;
         fill  <= '0;
         phase <= 1'b0;
      end else if (clr) begin
         win   <= '0;
         fill  <= '0;
         phase <= 1'b0;
      end else if (take) begin
         win   <= win_nxt;
         fill  <= fill_inc;
         phase <= ~phase;
      end
   end
endmodule

module dwt_envelope_pipe #(
   parameter int N_LEVEL   = 3,
   parameter int DATA_W    = 32,
   parameter int COEF_W    = 16,
   parameter int COEF_FRAC = 15,
   parameter int N_TAPS    = 20
) (
   input  logic                       CLK,
   input  logic                       RST,
   input  logic                       clr,
   input  logic                       coef_we,
   input  logic [$clog2(N_TAPS)-1:0]  coef_addr,
   input  logic [COEF_W-1:0]          coef_data,
   input  logic                       band_sel,
   input  logic                       abs_en,
   input  logic                       in_valid,
   input  logic [DATA_W-1:0]          in_data,
   output logic                       in_ready,
   output logic                       out_valid,
   output logic [DATA_W-1:0]          out_data,
   input  logic                       out_ready
);
   localparam int NP = (N_LEVEL > 1) ? N_LEVEL - 1 : 1;

   logic [N_TAPS-1:0][COEF_W-1:0]  h;
   logic                           stall;
   logic [NP-1:0]                  vld_pipe;   // level l approximation valid, feeding level l+1
   logic [NP-1:0][DATA_W-1:0]      dat_pipe;
   logic [N_LEVEL-1:0]             emit;
   logic [N_LEVEL-1:0][DATA_W-1:0] y;

   // Magnitude with the most negative value saturated to the positive limit.
   function automatic logic [DATA_W-1:0] env(input logic [DATA_W-1:0] v, input logic en);
      if (!en || !v[DATA_W-1])                   return v;
      else if (v == {1'b1, {(DATA_W-1){1'b0}}}) return {1'b0, {(DATA_W-1){1'b1}}};
      else                                       return -v;
   endfunction

   assign stall    = out_valid & ~out_ready;
   assign in_ready = ~stall;

   // Coefficient RAM; survives clr, out-of-range addresses are dropped.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) h <= '0;
      else if (coef_we && (32'(coef_addr) < N_TAPS)) h[coef_addr] <= coef_data;
   end

   for (genvar l = 0; l < N_LEVEL; l++) begin : g_lvl
      logic              v_in;
      logic [DATA_W-1:0] x_in;
      if (l == 0) begin : g_head
         assign v_in = in_valid;
         assign x_in = in_data;
      end else begin : g_tail
         assign v_in = vld_pipe[l-1];
         assign x_in = dat_pipe[l-1];
      end
      dwt_level #(.DATA_W(DATA_W), .COEF_W(COEF_W), .COEF_FRAC(COEF_FRAC), .N_TAPS(N_TAPS)) u_lvl (
         .CLK   (CLK),
         .RST   (RST),
         .clr   (clr),
         .take  (v_in & ~stall),
         .x_in  (x_in),
         .h     (h),
         .sel_d ((l == N_LEVEL - 1) ? band_sel : 1'b0),
         .emit  (emit[l]),
         .y     (y[l])
      );
   end

   // Inter-level registers and the held output; everything freezes on stall.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         vld_pipe  <= '0;
         dat_pipe  <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
      end else if (clr) begin
         vld_pipe  <= '0;
         dat_pipe  <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
      end else if (!stall) begin
         for (int l = 0; l < N_LEVEL - 1; l++) begin
            vld_pipe[l] <= emit[l];
            if (emit[l]) dat_pipe[l] <= y[l];
         end
         if (emit[N_LEVEL-1]) begin
            out_valid <= 1'b1;
            out_data  <= env(y[N_LEVEL-1], abs_en);
         end else begin
            out_valid <= 1'b0;
         end
      end
   end
endmodule
